// File: rtl/ps2_host_ctrl.sv
// ps2_host_ctrl
//   Host-side PS/2 protocol sequencer. Receives device-to-host frames,
//   performs host-to-device transmit (inhibit, request-to-send, bit shifting,
//   ACK check) and drives the open-drain pull-low enables of both lines.
//
// Ports
//   clk, reset_n        system clock, asynchronous active-low reset
//   ps2_clk_s           synchronized PS/2 clock line level
//   ps2_data_s          synchronized PS/2 data line level
//   ps2_clk_oe          1 = pull PS/2 clock low
//   ps2_data_oe         1 = pull PS/2 data low
//   tx_valid / tx_data  host byte request and the byte to send
//   tx_ready            request is accepted this cycle
//   tx_done             one-cycle pulse: device ACKed the byte
//   tx_err              one-cycle pulse: no ACK, or transmit timeout
//   rx_valid / rx_data  one-cycle pulse / last received byte (held)
//   rx_err              one-cycle pulse: parity, stop or receive timeout
//   busy                controller is not idle
module ps2_host_ctrl #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 20
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk_s,
  input  logic       ps2_data_s,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, RX_BITS, TX_INHIBIT, TX_BITS, TX_ACK, TX_WAIT_IDLE
  } state_t;

  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  // One cycle before the counter would reach TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_d;
  logic             clk_prev;
  logic             fall;
  logic [3:0]       bitcnt, bitcnt_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [8:0]       rx_sh, rx_sh_d;   // {parity, data} as it shifts in
  logic [8:0]       tx_sh, tx_sh_d;   // {parity, data} still to shift out
  logic             clk_oe_d, data_oe_d;
  logic             tx_done_d, tx_err_d, rx_valid_d, rx_err_d;
  logic [7:0]       rx_data_d;
  logic             timeout;

  assign fall     = clk_prev & ~ps2_clk_s;
  assign tx_ready = (state == IDLE) & ~fall;   // a start-bit fall beats a request
  assign busy     = (state != IDLE);
  assign timeout  = ~fall & (cnt == TIMEOUT_LAST);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d    = state;
    bitcnt_d   = bitcnt;
    cnt_d      = fall ? '0 : cnt + CNT_W'(1);
    rx_sh_d    = rx_sh;
    tx_sh_d    = tx_sh;
    clk_oe_d   = 1'b0;
    data_oe_d  = ps2_data_oe;
    tx_done_d  = 1'b0;
    tx_err_d   = 1'b0;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    rx_data_d  = rx_data;

    unique case (state)
      IDLE: begin
        cnt_d     = '0;
        data_oe_d = 1'b0;
        if (fall && !ps2_data_s) begin
          state_d  = RX_BITS;
          bitcnt_d = '0;
        end else if (tx_valid && tx_ready) begin
          tx_sh_d  = {~^tx_data, tx_data};   // odd parity
          clk_oe_d = 1'b1;
          state_d  = TX_INHIBIT;
        end
      end

      RX_BITS: begin
        data_oe_d = 1'b0;
        if (fall) begin
          if (bitcnt == 4'd9) begin
            rx_data_d  = rx_sh[7:0];
            rx_valid_d = 1'b1;
            rx_err_d   = ~(^rx_sh) | ~ps2_data_s;
            state_d    = IDLE;
          end else begin
            rx_sh_d  = {ps2_data_s, rx_sh[8:1]};
            bitcnt_d = bitcnt + 4'd1;
          end
        end else if (timeout) begin
          rx_err_d = 1'b1;
          state_d  = IDLE;
        end
      end

      TX_INHIBIT: begin
        // Our own pull-down produces a fall here; it must not restart the count.
        cnt_d    = cnt + CNT_W'(1);
        clk_oe_d = 1'b1;
        if (cnt == INHIBIT_LAST) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;                  // start bit / request-to-send
          bitcnt_d  = '0;
          cnt_d     = '0;
          state_d   = TX_BITS;
        end
      end

      TX_BITS: begin
        if (fall) begin
          if (bitcnt == 4'd9) begin
            data_oe_d = 1'b0;                // stop bit: release data
            state_d   = TX_ACK;
          end else begin
            data_oe_d = ~tx_sh[0];
            tx_sh_d   = tx_sh >> 1;
            bitcnt_d  = bitcnt + 4'd1;
          end
        end else if (timeout) begin
          data_oe_d = 1'b0;
          tx_err_d  = 1'b1;
          state_d   = IDLE;
        end
      end

      TX_ACK: begin
        if (fall) begin
          tx_done_d = ~ps2_data_s;
          tx_err_d  = ps2_data_s;
          state_d   = TX_WAIT_IDLE;
        end else if (timeout) begin
          data_oe_d = 1'b0;
          tx_err_d  = 1'b1;
          state_d   = IDLE;
        end
      end

      TX_WAIT_IDLE: begin
        if (ps2_clk_s && ps2_data_s) begin
          state_d = IDLE;
        end else if (timeout) begin
          data_oe_d = 1'b0;
          tx_err_d  = 1'b1;
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      clk_prev    <= 1'b1;
      bitcnt      <= '0;
      cnt         <= '0;
      rx_sh       <= '0;
      tx_sh       <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
      rx_valid    <= 1'b0;
      rx_err      <= 1'b0;
      rx_data     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state       <= state_d;
      clk_prev    <= ps2_clk_s;
      bitcnt      <= bitcnt_d;
      cnt         <= cnt_d;
      rx_sh       <= rx_sh_d;
      tx_sh       <= tx_sh_d;
      ps2_clk_oe  <= clk_oe_d;
      ps2_data_oe <= data_oe_d;
      tx_done     <= tx_done_d;
      tx_err      <= tx_err_d;
      rx_valid    <= rx_valid_d;
      rx_err      <= rx_err_d;
      rx_data     <= rx_data_d;
    end
  end

endmodule

// File: tb/tb_ps2_host_ctrl.sv
`timescale 1ns/1ps
module tb_ps2_host_ctrl;

  localparam int INH = 100;
  localparam int TMO = 2000;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       dev_clk, dev_data;
  logic       ps2_clk_s, ps2_data_s, ps2_clk_oe, ps2_data_oe;
  logic       tx_valid, tx_ready, tx_done, tx_err, rx_valid, rx_err, busy;
  logic [7:0] tx_data, rx_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_fall_cyc = 0;

  // Monitor state
  logic [8:0] rxq[$];        // {rx_err, rx_data} at each rx_valid
  int         inh_q[$];      // length of each ps2_clk_oe high run
  logic       start_q[$];    // ps2_data_oe in the cycle the inhibit ended
  int         inh_run = 0;
  int         rx_err_solo = 0;
  int         rx_err_solo_cyc = 0;
  int         tx_done_cnt = 0;
  int         tx_err_cnt = 0;
  int         viol = 0;

  // Open-drain wired-AND of device and host.
  assign ps2_clk_s  = dev_clk  & ~ps2_clk_oe;
  assign ps2_data_s = dev_data & ~ps2_data_oe;

  ps2_host_ctrl #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .CNT_W(20)) dut (
    .clk(clk), .reset_n(reset_n),
    .ps2_clk_s(ps2_clk_s), .ps2_data_s(ps2_data_s),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .tx_done(tx_done), .tx_err(tx_err),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_err(rx_err),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) rxq.push_back({rx_err, rx_data});
    else if (rx_err) begin
      rx_err_solo     <= rx_err_solo + 1;
      rx_err_solo_cyc <= cyc;
    end
    if (tx_done) tx_done_cnt <= tx_done_cnt + 1;
    if (tx_err)  tx_err_cnt  <= tx_err_cnt + 1;
    viol <= viol + int'(tx_done && tx_err) + int'(ps2_data_oe && !busy)
                 + int'(ps2_clk_oe && ps2_data_oe);
    if (ps2_clk_oe) inh_run <= inh_run + 1;
    else if (inh_run > 0) begin
      inh_q.push_back(inh_run);
      start_q.push_back(ps2_data_oe);
      inh_run <= 0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle; completes a pending tx handshake.
  task automatic tick();
    logic take;
    #1;
    take = tx_valid && tx_ready;
    @(negedge clk);
    #1;
    if (take) tx_valid = 1'b0;
  endtask

  // Device-to-host frame: start, 8 data LSB first, parity, stop; first nbits only.
  task automatic dev_send(input logic [7:0] b, input logic par, input logic stop,
                          input int nbits, input logic tx_at_start, input logic [7:0] txb);
    logic [10:0] f;
    f = {stop, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      dev_data = f[i];
      repeat (20) tick();
      dev_clk = 1'b0;
      last_fall_cyc = cyc;
      if (i == 0 && tx_at_start) begin
        tx_valid = 1'b1;
        tx_data  = txb;
        #1;
        check("tx_ready_on_start_fall", tx_ready, 1'b0);
      end
      repeat (40) tick();
      dev_clk = 1'b1;
      repeat (20) tick();
    end
    dev_data = 1'b1;
  endtask

  // Device side of host-to-device: wait for start bit, clock 11 pulses,
  // sample 8 data + parity + stop, then answer with ack on pulse 11.
  task automatic tx_device(input logic ack, output logic [9:0] got, output logic ok);
    int n;
    n = 0;
    got = '0;
    while (!(ps2_data_oe && !ps2_clk_oe) && n < 1000) begin
      tick();
      n++;
    end
    ok = (n < 1000);
    if (ok) begin
      for (int k = 0; k < 11; k++) begin
        if (k == 10) dev_data = ack;
        repeat (20) tick();
        dev_clk = 1'b0;
        repeat (30) tick();
        if (k < 10) got[k] = ps2_data_s;
        repeat (10) tick();
        dev_clk = 1'b1;
        repeat (20) tick();
      end
      dev_data = 1'b1;
    end
  endtask

  task automatic run_rx(input string tag, input logic [7:0] b, input logic par,
                        input logic stop, input logic tx_at_start, input logic [7:0] txb);
    logic       exp_err;
    logic [8:0] e;
    exp_err = (^{b, par} == 1'b0) || !stop;
    rxq.delete();
    dev_send(b, par, stop, 11, tx_at_start, txb);
    repeat (5) tick();
    check({tag, "_rx_count"}, rxq.size(), 1);
    if (rxq.size() > 0) e = rxq.pop_front();
    else e = '1;
    check({tag, "_rx_data"}, e[7:0], b);
    check({tag, "_rx_err"}, e[8], exp_err);
    if (!tx_at_start) check({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic run_tx(input string tag, input logic [7:0] b, input logic ack,
                        input logic already_requested);
    logic [9:0] got;
    logic       ok;
    int         d0, e0, n, inh;
    logic       sb;
    if (!already_requested) begin
      tx_valid = 1'b1;
      tx_data  = b;
    end
    d0 = tx_done_cnt;
    e0 = tx_err_cnt;
    tx_device(ack, got, ok);
    check({tag, "_start_seen"}, ok, 1'b1);
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_bits"}, got, {1'b1, ~^b, b});
    if (inh_q.size() > 0) inh = inh_q.pop_front();
    else inh = -1;
    if (start_q.size() > 0) sb = start_q.pop_front();
    else sb = 1'b0;
    check({tag, "_inhibit_len"}, inh, INH);
    check({tag, "_start_bit"}, sb, 1'b1);
    check({tag, "_tx_done"}, tx_done_cnt - d0, ack ? 0 : 1);
    check({tag, "_tx_err"}, tx_err_cnt - e0, ack ? 1 : 0);
    check({tag, "_idle"}, busy, 1'b0);
    check({tag, "_tx_ready"}, tx_ready, 1'b1);
  endtask

  initial begin
    logic [7:0] b;
    logic       par, stop, ack;
    int         s0, n, lat;

    reset_n  = 1'b0;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    tx_valid = 1'b0;
    tx_data  = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_clk_oe", ps2_clk_oe, 1'b0);
    check("rst_data_oe", ps2_data_oe, 1'b0);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_rx_err", rx_err, 1'b0);
    check("rst_tx_done", tx_done, 1'b0);
    check("rst_tx_err", tx_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset_n = 1'b1;
    repeat (5) tick();

    // Directed receive: good frame, then bad parity.
    run_rx("rx_1c", 8'h1C, 1'b0, 1'b1, 1'b0, 8'h00);
    run_rx("rx_1c_badpar", 8'h1C, 1'b1, 1'b1, 1'b0, 8'h00);

    // Directed transmit: ACK, then no ACK.
    run_tx("tx_ed_ack", 8'hED, 1'b0, 1'b0);
    run_tx("tx_ed_nack", 8'hED, 1'b1, 1'b0);

    // Device stops clocking after start + 4 data bits.
    rxq.delete();
    s0 = rx_err_solo;
    dev_send(8'hA5, 1'b0, 1'b1, 5, 1'b0, 8'h00);
    n = 0;
    while (rx_err_solo == s0 && n < 3000) begin
      tick();
      n++;
    end
    lat = rx_err_solo_cyc - last_fall_cyc;
    check("rx_timeout_err", rx_err_solo - s0, 1);
    check("rx_timeout_latency_near_2000", (lat >= TMO - 5) && (lat <= TMO + 10), 1'b1);
    check("rx_timeout_no_valid", rxq.size(), 0);
    check("rx_timeout_clk_oe", ps2_clk_oe, 1'b0);
    check("rx_timeout_data_oe", ps2_data_oe, 1'b0);
    check("rx_timeout_idle", busy, 1'b0);

    // Transmit request in the same cycle as a start-bit fall.
    run_rx("both_rx", 8'h5A, ~^8'h5A, 1'b1, 1'b1, 8'h3C);
    run_tx("both_tx", 8'h3C, 1'b0, 1'b1);

    // Randomized receive frames (parity and stop occasionally wrong).
    for (int i = 0; i < 4; i++) begin
      b    = 8'($urandom);
      par  = ($urandom_range(0, 1) == 1) ? ~^b : ^b;
      stop = ($urandom_range(0, 3) != 0);
      run_rx("rand_rx", b, par, stop, 1'b0, 8'h00);
    end

    // Randomized transmits with random ACK.
    for (int i = 0; i < 3; i++) begin
      b   = 8'($urandom);
      ack = 1'($urandom_range(0, 1));
      run_tx("rand_tx", b, ack, 1'b0);
    end

    // Reset during inhibit releases the clock line immediately.
    tx_valid = 1'b1;
    tx_data  = 8'h55;
    n = 0;
    while (!ps2_clk_oe && n < 50) begin
      tick();
      n++;
    end
    check("midframe_inhibit_seen", ps2_clk_oe, 1'b1);
    reset_n  = 1'b0;
    tx_valid = 1'b0;
    #1;
    check("midframe_rst_clk_oe", ps2_clk_oe, 1'b0);
    check("midframe_rst_data_oe", ps2_data_oe, 1'b0);
    check("midframe_rst_busy", busy, 1'b0);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (5) tick();
    inh_q.delete();
    start_q.delete();

    check("line_invariants", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_host_ctrl.md
Name: ps2_host_ctrl

Overview:
- Host-side PS/2 protocol sequencer that owns the bidirectional PS/2 clock and data lines.
- Consumes the synchronized PS/2 clock and data samples, assembles device-to-host frames and drives host-to-device transmit: inhibit, request-to-send, bit shifting and ACK check.
- Drives the open-drain pull-low enables and sits between the PS/2 line synchronizers and the Avalon slave register file.

Parameters:
- INHIBIT_CYCLES, 5000: clk cycles ps2 clock is held low before request-to-send (100 us @ 50 MHz).
- TIMEOUT_CYCLES, 1000000: max clk cycles allowed between ps2 clock falling edges inside a frame (20 ms @ 50 MHz).
- CNT_W, 20: width of the shared inhibit/timeout counter; must hold max(INHIBIT_CYCLES, TIMEOUT_CYCLES).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ps2_clk_s  in  1  synchronized PS/2 clock line level.
- ps2_data_s  in  1  synchronized PS/2 data line level.
- ps2_clk_oe  out  1  1 = pull PS/2 clock low.
- ps2_data_oe  out  1  1 = pull PS/2 data low.
- tx_valid  in  1  host byte request.
- tx_data  in  8  byte to send.
- tx_ready  out  1  controller can accept tx_data this cycle.
- tx_done  out  1  one-cycle pulse: device ACKed the byte.
- tx_err  out  1  one-cycle pulse: no ACK, or timeout during transmit.
- rx_valid  out  1  one-cycle pulse: frame received.
- rx_data  out  8  last received byte; holds until the next rx_valid.
- rx_err  out  1  one-cycle pulse: parity error, stop error, or receive timeout.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: every output 0, state IDLE, clock-edge history register 1, bit counter 0, timeout counter 0. Asserting reset mid-frame releases both lines immediately.
- Edge detect: fall = clk_prev & ~ps2_clk_s. clk_prev is registered every cycle.
- States: IDLE, RX_BITS, TX_INHIBIT, TX_BITS, TX_ACK, TX_WAIT_IDLE.
- IDLE transitions:
  - fall with ps2_data_s=0 (start bit) -> RX_BITS, bitcnt=0.
  - fall with ps2_data_s=1 -> ignored.
  - tx_valid & tx_ready -> latch tx_data, compute odd parity, -> TX_INHIBIT.
- tx_ready = (state==IDLE) & ~fall. Receive wins when a start-bit fall and tx_valid occur in the same cycle.
- RX_BITS:
  - Each fall samples ps2_data_s: bitcnt 0-7 are data LSB first, 8 is parity, 9 is stop.
  - On the stop fall, the next cycle updates rx_data and pulses rx_valid, then -> IDLE.
  - That same cycle pulses rx_err if parity is not odd over data+parity, or if stop=0. rx_data is still updated and rx_valid still pulses.
- TX_INHIBIT:
  - ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles.
  - On the following cycle ps2_clk_oe=0 and ps2_data_oe=1 (start bit), bitcnt=0, -> TX_BITS.
- TX_BITS:
  - On each fall, drive the next bit with ps2_data_oe = ~bit: bitcnt 0-7 data LSB first, 8 parity.
  - On fall number 10, release data (ps2_data_oe=0, stop bit) -> TX_ACK.
- TX_ACK: on the next fall, sample ps2_data_s.
  - 0 -> pulse tx_done.
  - 1 -> pulse tx_err.
  - Either way -> TX_WAIT_IDLE.
- TX_WAIT_IDLE: stay until ps2_clk_s=1 and ps2_data_s=1 in the same cycle -> IDLE.
- Timeout:
  - Counter clears on every fall and on state entry. It counts in RX_BITS, TX_BITS, TX_ACK and TX_WAIT_IDLE.
  - Reaching TIMEOUT_CYCLES releases both oe outputs and goes to IDLE.
  - Pulses rx_err if in RX_BITS, otherwise tx_err. No rx_valid on timeout.
- Pulse outputs are registered and high for exactly one cycle. tx_done and tx_err never assert together.
- ps2_clk_oe is only ever high in TX_INHIBIT. ps2_data_oe is never high in IDLE or RX_BITS.

Test Plan (INHIBIT_CYCLES=100, TIMEOUT_CYCLES=2000; PS/2 clock model period 80 clk):
- Device sends 0x1C, parity 0, stop 1 -> single rx_valid with rx_data=0x1C, rx_err=0, busy returns 0.
- Device sends 0x1C with parity 1 -> rx_valid with rx_data=0x1C plus rx_err pulse in the same cycle.
- tx_valid with tx_data=0xED -> ps2_clk_oe high exactly 100 cycles, then start bit. Device model samples 1,0,1,1,0,1,1,1, parity 1, stop 1. Model ACKs (data 0) -> tx_done pulse, tx_err=0.
- Same transmit with the model giving no ACK (data 1 on the ACK fall) -> tx_err pulse, then IDLE after lines go high, tx_ready=1.
- Device stops clocking after 4 bits of a receive -> 2000 cycles later rx_err pulse, no rx_valid, both oe=0, state IDLE.
- tx_valid asserted in the same cycle as a start-bit fall -> tx_ready=0, receive completes, then the transmit is accepted and completes normally.
